// File: rtl/fc_layer_if.sv
// fc_layer_if: run handshake plus layer-memory and weight-memory bus.
// master: fc_layer side. slave: controller / memory side.
//   start/busy/done        run control
//   crd/caddr_rd/cdata_rd  layer memory read port (sync, 1-cycle)
//   cwr/caddr_wr/cdata_wr  layer memory write port
//   csel                   layer memory bank select
//   wrd/waddr/wdata        weight memory read port (sync, 1-cycle)
interface fc_layer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;
  logic        wrd;
  logic [12:0] waddr;
  logic [19:0] wdata;

  modport master (
    input  start,
    input  cdata_rd,
    input  wdata,
    output busy,
    output done,
    output crd,
    output caddr_rd,
    output cwr,
    output caddr_wr,
    output cdata_wr,
    output csel,
    output wrd,
    output waddr
  );

  modport slave (
    output start,
    output cdata_rd,
    output wdata,
    input  busy,
    input  done,
    input  crd,
    input  caddr_rd,
    input  cwr,
    input  caddr_wr,
    input  cdata_wr,
    input  csel,
    input  wrd,
    input  waddr
  );
endinterface

// File: rtl/fc_layer.sv
// fc_layer: fully-connected stage over the flattened Q4.16 vector.
// Per output: dot product, + bias, round, saturate, optional ReLU, write.
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    fc_layer_if.master (start/busy/done, layer + weight memories)
module fc_layer #(
  parameter int         VEC_LEN = 2048,
  parameter int         N_OUT   = 2,
  parameter logic [2:0] IN_SEL  = 3'b101,
  parameter logic [2:0] OUT_SEL = 3'b110,
  parameter bit         RELU    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  fc_layer_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [11:0] I_LAST = 12'(VEC_LEN - 1);
  localparam logic [2:0]  O_LAST = 3'(N_OUT - 1);
  localparam logic [12:0] W_STEP = 13'(VEC_LEN);
  localparam logic [12:0] B_BASE = 13'(N_OUT * VEC_LEN);

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic        ph;
  logic [11:0] i;
  logic [2:0]  o;
  logic [12:0] wbase;

  logic        go;
  logic        fetch_last;
  logic        o_last;

  logic        dv;
  logic        pv;
  logic signed [39:0] xin;
  logic signed [39:0] win;
  logic signed [39:0] prod;
  logic signed [51:0] acc;
  logic        [19:0] bias;

  logic [36:0] r;
  logic        pos_ovf;
  logic        neg_ovf;
  logic [19:0] sat;
  logic [19:0] res;

  logic        busy_q;
  logic        done_q;
  logic        crd_q;
  logic        wrd_q;
  logic        cwr_q;
  logic [2:0]  csel_q;
  logic [12:0] waddr_q;
  logic [11:0] caddr_wr_q;
  logic [19:0] cdata_wr_q;

  assign go         = (state == S_IDLE) && bus.start;
  assign fetch_last = (i == I_LAST);
  assign o_last     = (o == O_LAST);

  // ---------------- FSM ----------------
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_n = S_FETCH;
      S_FETCH: if (fetch_last) state_n = S_DRAIN;
      S_DRAIN: if (ph) state_n = S_BIAS;
      S_BIAS:  if (ph) state_n = S_ROUND;
      S_ROUND: state_n = S_WRITE;
      S_WRITE: state_n = o_last ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // DRAIN and BIAS each last two cycles; ph marks the second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph <= 1'b0;
    end else begin
      ph <= ((state == S_DRAIN) || (state == S_BIAS)) && !ph;
    end
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i <= '0;
    end else if (go) begin
      i <= '0;
    end else if (state == S_FETCH) begin
      i <= fetch_last ? '0 : i + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o <= '0;
    end else if (go) begin
      o <= '0;
    end else if ((state == S_WRITE) && !o_last) begin
      o <= o + 3'd1;
    end
  end

  // wbase tracks o*VEC_LEN without a multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbase <= '0;
    end else if (go) begin
      wbase <= '0;
    end else if ((state == S_WRITE) && !o_last) begin
      wbase <= wbase + W_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr_q <= '0;
    end else if (go) begin
      waddr_q <= '0;
    end else begin
      unique case (state)
        S_FETCH: if (!fetch_last) waddr_q <= waddr_q + 13'd1;
        S_DRAIN: if (ph) waddr_q <= B_BASE + 13'(o);
        S_WRITE: if (!o_last) waddr_q <= wbase + W_STEP;
        default: ;
      endcase
    end
  end

  // ---------------- MAC pipeline ----------------
  assign xin = {{20{bus.cdata_rd[19]}}, bus.cdata_rd};
  assign win = {{20{bus.wdata[19]}}, bus.wdata};

  // dv: read data valid this cycle; pv: prod holds a fresh term.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv <= 1'b0;
      pv <= 1'b0;
    end else begin
      dv <= crd_q;
      pv <= dv;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0;
    end else if (dv) begin
      prod <= xin * win;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (go || (state == S_WRITE)) begin
      acc <= '0;
    end else if (pv) begin
      acc <= acc + {{12{prod[39]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bias <= '0;
    end else if ((state == S_BIAS) && ph) begin
      bias <= bus.wdata;
    end
  end

  // ---------------- round / saturate / relu ----------------
  // floor(acc/2^16) + acc[15] is round-half-up at bit 15.
  always_comb begin
    r = {acc[51], acc[51:16]}
      + {36'd0, acc[15]}
      + {{17{bias[19]}}, bias};
    pos_ovf = !r[36] && (r[35:19] != '0);
    neg_ovf = r[36] && (r[35:19] != '1);
    sat = r[19:0];
    if (pos_ovf) begin
      sat = 20'h7FFFF;
    end else if (neg_ovf) begin
      sat = 20'h80000;
    end
    res = (RELU && sat[19]) ? '0 : sat;
  end

  // ---------------- registered bus outputs ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      crd_q  <= 1'b0;
      wrd_q  <= 1'b0;
      cwr_q  <= 1'b0;
    end else begin
      busy_q <= (state_n != S_IDLE);
      done_q <= (state_n == S_DONE);
      crd_q  <= (state_n == S_FETCH);
      wrd_q  <= (state_n == S_FETCH)
             || ((state == S_DRAIN) && ph);
      cwr_q  <= (state_n == S_WRITE);
    end
  end

  // csel only moves when a strobe is about to rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csel_q <= '0;
    end else begin
      unique case (1'b1)
        (state_n == S_FETCH): csel_q <= IN_SEL;
        (state_n == S_WRITE): csel_q <= OUT_SEL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else if (state == S_ROUND) begin
      caddr_wr_q <= {9'd0, o};
      cdata_wr_q <= res;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crd      = crd_q;
  assign bus.caddr_rd = i;
  assign bus.wrd      = wrd_q;
  assign bus.waddr    = waddr_q;
  assign bus.cwr      = cwr_q;
  assign bus.csel     = csel_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: scoreboard bench, two DUTs (RELU=1 and RELU=0) on shared memories.
// Expected writes are queued at start; a negedge monitor pops and compares.
module tb_fc_layer;

  localparam int         V    = 2048;
  localparam int         N    = 2;
  localparam logic [2:0] ISEL = 3'b101;
  localparam logic [2:0] OSEL = 3'b110;
  localparam int         LAT  = 1 + N * (V + 6);

  typedef struct {
    int          addr;
    logic [19:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;

  always #5 clk = ~clk;

  fc_layer_if b0 ();
  fc_layer_if b1 ();

  assign b0.start = start;
  assign b1.start = start;

  fc_layer #(
    .VEC_LEN(V), .N_OUT(N), .IN_SEL(ISEL),
    .OUT_SEL(OSEL), .RELU(1'b1)
  ) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  fc_layer #(
    .VEC_LEN(V), .N_OUT(N), .IN_SEL(ISEL),
    .OUT_SEL(OSEL), .RELU(1'b0)
  ) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  logic [19:0] vmem [4096];
  logic [19:0] wmem [8192];

  exp_t q0[$];
  exp_t q1[$];
  logic [19:0] exp_r [N];
  logic [19:0] exp_n [N];

  int ncmp  = 0;
  int nfail = 0;
  int dcnt0 = 0;
  int dcnt1 = 0;
  int ovl   = 0;

  // synchronous memories, data one edge after the address
  always @(posedge clk) begin
    if (b0.crd)
      b0.cdata_rd <= (b0.csel == ISEL) ? vmem[b0.caddr_rd] : 20'h5A5A5;
    if (b0.wrd)
      b0.wdata <= wmem[b0.waddr];
    if (b1.crd)
      b1.cdata_rd <= (b1.csel == ISEL) ? vmem[b1.caddr_rd] : 20'h5A5A5;
    if (b1.wrd)
      b1.wdata <= wmem[b1.waddr];
  end

  task automatic check(input string nm,
                       input logic [95:0] got,
                       input logic [95:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic cmp_wr(input int k, input exp_t e,
                        input logic [11:0] a,
                        input logic [19:0] d,
                        input logic [2:0] s);
    ncmp++;
    if (a !== 12'(e.addr) || d !== e.data || s !== OSEL) begin
      nfail++;
      $display("FAIL wr%0d: got addr=%0d data=%05h csel=%b, want addr=%0d data=%05h csel=%b",
               k, a, d, s, e.addr, e.data, OSEL);
    end
  endtask

  task automatic unexp(input int k, input logic [11:0] a,
                       input logic [19:0] d);
    ncmp++;
    nfail++;
    $display("FAIL wr%0d_unexpected: got write addr=%0d data=%05h, want none",
             k, a, d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b0.cwr) begin
      if (q0.size() == 0) begin
        unexp(0, b0.caddr_wr, b0.cdata_wr);
      end else begin
        e = q0.pop_front();
        cmp_wr(0, e, b0.caddr_wr, b0.cdata_wr, b0.csel);
      end
    end
    if (b1.cwr) begin
      if (q1.size() == 0) begin
        unexp(1, b1.caddr_wr, b1.cdata_wr);
      end else begin
        e = q1.pop_front();
        cmp_wr(1, e, b1.caddr_wr, b1.cdata_wr, b1.csel);
      end
    end
    if ((b0.crd && b0.cwr) || (b1.crd && b1.cwr)) ovl++;
    if (b0.done) dcnt0++;
    if (b1.done) dcnt1++;
  end

  // reference model: exact integer dot product, then the output rules
  function automatic longint sx(input logic [19:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [19:0] ref_out(input int o, input bit relu);
    longint s;
    longint r;
    s = 0;
    for (int j = 0; j < V; j++)
      s += sx(vmem[j]) * sx(wmem[o * V + j]);
    r = (s + 64'sd32768) >>> 16;
    r += sx(wmem[N * V + o]);
    if (r > 64'sd524287) r = 64'sd524287;
    else if (r < -64'sd524288) r = -64'sd524288;
    if (relu && r < 0) r = 0;
    return r[19:0];
  endfunction

  task automatic clr();
    for (int j = 0; j < 4096; j++) vmem[j] = '0;
    for (int j = 0; j < 8192; j++) wmem[j] = '0;
  endtask

  task automatic set_exp(input logic [19:0] r0, input logic [19:0] r1,
                         input logic [19:0] n0, input logic [19:0] n1);
    exp_r[0] = r0;
    exp_r[1] = r1;
    exp_n[0] = n0;
    exp_n[1] = n1;
  endtask

  task automatic scen1();
    clr();
    wmem[N * V]     = 20'h01310;
    wmem[N * V + 1] = 20'hF7295;
    set_exp(20'h01310, 20'h00000, 20'h01310, 20'hF7295);
  endtask

  task automatic scen2();
    clr();
    vmem[5] = 20'h10000;
    wmem[5] = 20'h0A89E;
    set_exp(20'h0A89E, 20'h00000, 20'h0A89E, 20'h00000);
  endtask

  task automatic rand_fill();
    clr();
    for (int j = 0; j < V; j++)
      vmem[j] = 20'($urandom_range(0, 4095)) - 20'd2048;
    for (int j = 0; j < N * V; j++)
      wmem[j] = 20'($urandom_range(0, 4095)) - 20'd2048;
    for (int k = 0; k < N; k++)
      wmem[N * V + k] = 20'($urandom);
    for (int k = 0; k < N; k++) begin
      exp_r[k] = ref_out(k, 1'b1);
      exp_n[k] = ref_out(k, 1'b0);
    end
  endtask

  task automatic run(input string nm, input bit extra);
    int n;
    int d0;
    int d1;
    for (int k = 0; k < N; k++) begin
      q0.push_back('{k, exp_r[k]});
      q1.push_back('{k, exp_n[k]});
    end
    d0 = dcnt0;
    d1 = dcnt1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!b0.done && n < LAT + 2000) begin
      @(negedge clk);
      n++;
      start = extra && (n == 50);
    end
    check($sformatf("%s_latency", nm), n, LAT);
    if (extra) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (6) @(negedge clk);
    check($sformatf("%s_done0", nm), dcnt0 - d0, 1);
    check($sformatf("%s_done1", nm), dcnt1 - d1, 1);
    check($sformatf("%s_idle", nm), {b0.busy, b1.busy}, 2'b00);
    check($sformatf("%s_pending", nm), q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic chk_zero(input string nm);
    check($sformatf("%s_b0", nm),
          {b0.busy, b0.done, b0.crd, b0.caddr_rd, b0.cwr, b0.caddr_wr,
           b0.cdata_wr, b0.csel, b0.wrd, b0.waddr}, '0);
    check($sformatf("%s_b1", nm),
          {b1.busy, b1.done, b1.crd, b1.caddr_rd, b1.cwr, b1.caddr_wr,
           b1.cdata_wr, b1.csel, b1.wrd, b1.waddr}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    reset = 1'b1;
    @(negedge clk);

    scen1();
    run("zero_vec", 1'b0);

    scen2();
    run("single_term", 1'b0);

    clr();
    vmem[0] = 20'h00001;
    wmem[0] = 20'h08000;
    set_exp(20'h00001, 20'h00000, 20'h00001, 20'h00000);
    run("round_up", 1'b0);

    wmem[0] = 20'h07FFF;
    set_exp(20'h00000, 20'h00000, 20'h00000, 20'h00000);
    run("round_down", 1'b0);

    clr();
    for (int j = 0; j < V; j++) vmem[j] = 20'h7FFFF;
    for (int j = 0; j < N * V; j++) wmem[j] = 20'h7FFFF;
    set_exp(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    run("sat_pos", 1'b0);

    for (int j = 0; j < N * V; j++) wmem[j] = 20'h80001;
    set_exp(20'h00000, 20'h00000, 20'h80000, 20'h80000);
    run("sat_neg", 1'b0);

    scen1();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (998) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("midrun_reset");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run("after_reset", 1'b0);

    scen2();
    run("start_busy", 1'b1);

    rand_fill();
    run("random_a", 1'b0);
    rand_fill();
    run("random_b", 1'b0);

    check("rd_wr_overlap", ovl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             ncmp, nfail);
    $finish;
  end

endmodule
